// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read cache controller with a line-refill FSM, deferred flush
// and saturating hit/miss counters.
// Ports: clk/rst_n (async active-low); req_* word-address request (valid/ready);
//        resp_* one-cycle response pulse; flush pulse; mem_req_* line fetch
//        (valid/ready); mem_rsp_* in-order data beats; hit_cnt/miss_cnt counters.
module dm_cache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int WORD_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                resp_valid,
  output logic [WORD_W-1:0]   resp_data,
  output logic                resp_hit,
  input  logic                flush,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_rsp_valid,
  input  logic [WORD_W-1:0]   mem_rsp_data,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MISS_REQ, REFILL, RESP, FLUSH
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic [LINES-1:0]    valid_q;
  logic                flush_pend, flush_pend_n;
  logic [OFFSET_W-1:0] beat_q, beat_n;

  logic                req_ready_n, resp_valid_n, resp_hit_n, mem_req_valid_n;
  logic [WORD_W-1:0]   resp_data_n;
  logic [ADDR_W-1:0]   mem_req_addr_n;
  logic [CNT_W-1:0]    hit_cnt_n, miss_cnt_n;

  logic                valid_clr, valid_set, data_we, tag_we;

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [WORD_W-1:0]   data_mem [LINES*WORDS];

  logic [TAG_W-1:0]    cur_tag;
  logic [INDEX_W-1:0]  cur_idx;
  logic [OFFSET_W-1:0] cur_off;
  logic                lookup_hit;

  assign cur_tag    = addr_q[ADDR_W-1 -: TAG_W];
  assign cur_idx    = addr_q[OFFSET_W +: INDEX_W];
  assign cur_off    = addr_q[OFFSET_W-1:0];
  assign lookup_hit = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);

  always_comb begin
    state_n         = state;
    addr_n          = addr_q;
    flush_pend_n    = flush_pend | flush;
    beat_n          = beat_q;
    resp_valid_n    = 1'b0;
    resp_data_n     = resp_data;
    resp_hit_n      = resp_hit;
    mem_req_valid_n = mem_req_valid;
    mem_req_addr_n  = mem_req_addr;
    hit_cnt_n       = hit_cnt;
    miss_cnt_n      = miss_cnt;
    valid_clr       = 1'b0;
    valid_set       = 1'b0;
    data_we         = 1'b0;
    tag_we          = 1'b0;

    case (state)
      IDLE: begin
        // req_ready is already low whenever a flush is pending, so the
        // pending flush wins. A flush pulse arriving alongside an accepted
        // request is only latched and runs after that request completes.
        if (flush_pend) begin
          state_n = FLUSH;
        end else if (req_valid && req_ready) begin
          addr_n  = req_addr;
          state_n = LOOKUP;
        end else if (flush) begin
          state_n = FLUSH;
        end
      end
      LOOKUP: begin
        if (lookup_hit) begin
          resp_data_n  = data_mem[{cur_idx, cur_off}];
          resp_hit_n   = 1'b1;
          resp_valid_n = 1'b1;
          hit_cnt_n    = (hit_cnt == '1) ? hit_cnt : hit_cnt + 1'b1;
          state_n      = RESP;
        end else begin
          miss_cnt_n      = (miss_cnt == '1) ? miss_cnt : miss_cnt + 1'b1;
          mem_req_valid_n = 1'b1;
          mem_req_addr_n  = {cur_tag, cur_idx, {OFFSET_W{1'b0}}};
          state_n         = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_n = 1'b0;
          beat_n          = '0;
          state_n         = REFILL;
        end
      end
      REFILL: begin
        if (mem_rsp_valid) begin
          data_we = 1'b1;
          beat_n  = beat_q + 1'b1;
          if (beat_q == cur_off) resp_data_n = mem_rsp_data;
          if (beat_q == '1) begin
            tag_we       = 1'b1;
            valid_set    = 1'b1;
            resp_hit_n   = 1'b0;
            resp_valid_n = 1'b1;
            state_n      = RESP;
          end
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      FLUSH: begin
        valid_clr    = 1'b1;
        // A fresh pulse during the flush cycle itself stays pending.
        flush_pend_n = flush;
        state_n      = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    req_ready_n = (state_n == IDLE) && !flush_pend_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      valid_q       <= '0;
      flush_pend    <= 1'b0;
      beat_q        <= '0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_hit      <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      state         <= state_n;
      addr_q        <= addr_n;
      flush_pend    <= flush_pend_n;
      beat_q        <= beat_n;
      req_ready     <= req_ready_n;
      resp_valid    <= resp_valid_n;
      resp_data     <= resp_data_n;
      resp_hit      <= resp_hit_n;
      mem_req_valid <= mem_req_valid_n;
      mem_req_addr  <= mem_req_addr_n;
      hit_cnt       <= hit_cnt_n;
      miss_cnt      <= miss_cnt_n;
      if (valid_clr) begin
        valid_q <= '0;
      end else if (valid_set) begin
        valid_q[cur_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_mem[{cur_idx, beat_q}] <= mem_rsp_data;
    if (tag_we)  tag_mem[cur_idx] <= cur_tag;
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: a default-parameter instance plus a
// small instance (16-bit address, 16 lines of 4 words, 4-bit counters).
module tb_dm_cache_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // default-parameter instance
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_addr = '0;
  logic        resp_valid, resp_hit;
  logic [31:0] resp_data;
  logic        flush = 1'b0;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic [31:0] hit_cnt, miss_cnt;

  dm_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // small instance
  logic        p_req_valid = 1'b0, p_req_ready;
  logic [15:0] p_req_addr = '0;
  logic        p_resp_valid, p_resp_hit;
  logic [31:0] p_resp_data;
  logic        p_flush = 1'b0;
  logic        p_mem_req_valid, p_mem_req_ready = 1'b0;
  logic [15:0] p_mem_req_addr;
  logic        p_mem_rsp_valid = 1'b0;
  logic [31:0] p_mem_rsp_data = '0;
  logic [3:0]  p_hit_cnt, p_miss_cnt;

  dm_cache_ctrl #(.ADDR_W(16), .WORD_W(32), .INDEX_W(4), .OFFSET_W(2), .CNT_W(4)) dut_p (
    .clk(clk), .rst_n(rst_n),
    .req_valid(p_req_valid), .req_ready(p_req_ready), .req_addr(p_req_addr),
    .resp_valid(p_resp_valid), .resp_data(p_resp_data), .resp_hit(p_resp_hit),
    .flush(p_flush),
    .mem_req_valid(p_mem_req_valid), .mem_req_ready(p_mem_req_ready), .mem_req_addr(p_mem_req_addr),
    .mem_rsp_valid(p_mem_rsp_valid), .mem_rsp_data(p_mem_rsp_data),
    .hit_cnt(p_hit_cnt), .miss_cnt(p_miss_cnt)
  );

  // ---------------- drivers for the default instance ----------------
  // All drivers start and end on a falling edge.
  task automatic issue(input logic [31:0] a, output int acc_cyc);
    int n = 0;
    while (!req_ready && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL issue_wait addr=%h: req_ready=%b, required 1", a, req_ready);
    end
    req_valid = 1'b1; req_addr = a;
    @(posedge clk); #1 acc_cyc = cyc;
    @(negedge clk); req_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output logic h, output int lat);
    int n = 0;
    while (!resp_valid && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (resp_valid !== 1'b1) begin
      errors++; $display("FAIL resp_wait: resp_valid=%b, required 1", resp_valid);
    end
    d = resp_data; h = resp_hit; lat = n + 1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++; $display("FAIL resp_pulse: resp_valid=%b one cycle later, required 0", resp_valid);
    end
  endtask

  task automatic mem_accept(input logic [31:0] exp_addr, input int hold, input bit stray);
    int n = 0;
    while (!mem_req_valid && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr) begin
      errors++; $display("FAIL mem_req: valid=%b addr=%h, required 1 %h", mem_req_valid, mem_req_addr, exp_addr);
    end
    if (stray) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
      @(negedge clk); mem_rsp_valid = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== exp_addr) begin
        errors++; $display("FAIL mem_req_hold cycle %0d: valid=%b addr=%h, required 1 %h", i, mem_req_valid, mem_req_addr, exp_addr);
      end
    end
    mem_req_ready = 1'b1;
    @(negedge clk); mem_req_ready = 1'b0;
  endtask

  task automatic mem_beats(input logic [31:0] base, input int from, input int upto, input int gap);
    for (int k = from; k < upto; k++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = base + k;
      @(negedge clk); mem_rsp_valid = 1'b0;
      if (k != upto - 1) repeat (gap) @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_hit, mem_req_valid} !== 4'b0 || hit_cnt !== 0 || miss_cnt !== 0
        || resp_data !== 0 || mem_req_addr !== 0) begin
      errors++; $display("FAIL reset_outputs: rdy=%b rv=%b rh=%b mv=%b hc=%0d mc=%0d rd=%h ma=%h, required all 0",
                         req_ready, resp_valid, resp_hit, mem_req_valid, hit_cnt, miss_cnt, resp_data, mem_req_addr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: req_ready=%b, required 1", req_ready);
    end
  endtask

  task automatic test_cold_miss_hit();
    int a; logic [31:0] d; logic h; int lat;
    issue(32'h0000_1234, a);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL miss_lookup_cycle: mem_req_valid=%b in LOOKUP, required 0", mem_req_valid);
    end
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++; $display("FAIL miss_req_latency: mem_req_valid=%b, required 1", mem_req_valid);
    end
    mem_accept(32'h0000_1230, 0, 1'b0);
    mem_beats(32'hA000_0000, 0, 16, 0);
    wait_resp(d, h, lat);
    checks++;
    if (d !== 32'hA000_0004 || h !== 1'b0 || miss_cnt !== 1) begin
      errors++; $display("FAIL cold_miss: data=%h hit=%b miss_cnt=%0d, required a0000004 0 1", d, h, miss_cnt);
    end
    issue(32'h0000_1237, a);
    wait_resp(d, h, lat);
    checks++;
    if (d !== 32'hA000_0007 || h !== 1'b1 || hit_cnt !== 1 || lat !== 2) begin
      errors++; $display("FAIL warm_hit: data=%h hit=%b hit_cnt=%0d lat=%0d, required a0000007 1 1 2", d, h, hit_cnt, lat);
    end
  endtask

  task automatic test_conflict();
    int a; logic [31:0] d; logic h; int lat;
    issue(32'h0000_2234, a);
    mem_accept(32'h0000_2230, 0, 1'b0);
    mem_beats(32'hB000_0000, 0, 16, 0);
    wait_resp(d, h, lat);
    checks++;
    if (d !== 32'hB000_0004 || h !== 1'b0 || miss_cnt !== 2) begin
      errors++; $display("FAIL conflict_fill: data=%h hit=%b miss_cnt=%0d, required b0000004 0 2", d, h, miss_cnt);
    end
    issue(32'h0000_1234, a);
    mem_accept(32'h0000_1230, 0, 1'b0);
    mem_beats(32'hA000_0000, 0, 16, 0);
    wait_resp(d, h, lat);
    checks++;
    if (d !== 32'hA000_0004 || h !== 1'b0 || miss_cnt !== 3 || hit_cnt !== 1) begin
      errors++; $display("FAIL conflict_evict: data=%h hit=%b miss=%0d hit_cnt=%0d, required a0000004 0 3 1", d, h, miss_cnt, hit_cnt);
    end
  endtask

  task automatic test_flush_idle();
    int a; logic [31:0] d; logic h; int lat;
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready_low: req_ready=%b, required 0", req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ready_back: req_ready=%b, required 1", req_ready);
    end
    issue(32'h0000_1234, a);
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle_miss: mem_req_valid=%b resp_valid=%b, required 1 0", mem_req_valid, resp_valid);
    end
    mem_accept(32'h0000_1230, 0, 1'b0);
    mem_beats(32'hA000_0000, 0, 16, 0);
    wait_resp(d, h, lat);
    checks++;
    if (hit_cnt !== 1 || miss_cnt !== 4 || h !== 1'b0) begin
      errors++; $display("FAIL flush_counters: hit_cnt=%0d miss_cnt=%0d hit=%b, required 1 4 0", hit_cnt, miss_cnt, h);
    end
  endtask

  task automatic test_backpressure();
    int a; logic [31:0] d; logic h; int lat;
    issue(32'h0000_5678, a);
    mem_accept(32'h0000_5670, 5, 1'b1);
    mem_beats(32'hC000_0000, 0, 16, 3);
    wait_resp(d, h, lat);
    checks++;
    if (d !== 32'hC000_0008 || h !== 1'b0 || miss_cnt !== 5) begin
      errors++; $display("FAIL backpressure_data: data=%h hit=%b miss_cnt=%0d, required c0000008 0 5", d, h, miss_cnt);
    end
  endtask

  task automatic test_flush_refill();
    int a; logic [31:0] d; logic h; int lat;
    issue(32'h0000_9AB1, a);
    mem_accept(32'h0000_9AB0, 0, 1'b0);
    mem_beats(32'hD000_0000, 0, 3, 0);
    flush = 1'b1;
    mem_beats(32'hD000_0000, 3, 4, 0);
    flush = 1'b0;
    mem_beats(32'hD000_0000, 4, 16, 0);
    wait_resp(d, h, lat);
    checks++;
    if (d !== 32'hD000_0001 || h !== 1'b0 || miss_cnt !== 6) begin
      errors++; $display("FAIL flush_refill_resp: data=%h hit=%b miss_cnt=%0d, required d0000001 0 6", d, h, miss_cnt);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL flush_refill_pending: req_ready=%b after response, required 0", req_ready);
    end
    issue(32'h0000_9AB1, a);
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL flush_refill_miss: mem_req_valid=%b resp_valid=%b, required 1 0", mem_req_valid, resp_valid);
    end
    mem_accept(32'h0000_9AB0, 0, 1'b0);
    mem_beats(32'hD000_0000, 0, 16, 0);
    wait_resp(d, h, lat);
    checks++;
    if (d !== 32'hD000_0001 || miss_cnt !== 7 || hit_cnt !== 1) begin
      errors++; $display("FAIL flush_refill_reread: data=%h miss=%0d hit_cnt=%0d, required d0000001 7 1", d, miss_cnt, hit_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2; logic [31:0] d1, d2; logic h1, h2; int lat;
    issue(32'h0000_9AB2, a1);
    wait_resp(d1, h1, lat);
    issue(32'h0000_9AB3, a2);
    wait_resp(d2, h2, lat);
    checks++;
    if (d1 !== 32'hD000_0002 || d2 !== 32'hD000_0003 || h1 !== 1'b1 || h2 !== 1'b1) begin
      errors++; $display("FAIL b2b_data: d1=%h d2=%h h=%b%b, required d0000002 d0000003 11", d1, d2, h1, h2);
    end
    checks++;
    if (a2 - a1 !== 3 || hit_cnt !== 3) begin
      errors++; $display("FAIL b2b_spacing: spacing=%0d hit_cnt=%0d, required 3 3", a2 - a1, hit_cnt);
    end
  endtask

  task automatic test_reset_mid_refill();
    int a; logic [31:0] d; logic h; int lat;
    issue(32'h0000_E004, a);
    mem_accept(32'h0000_E000, 0, 1'b0);
    mem_beats(32'hE000_0000, 0, 4, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_hit, mem_req_valid} !== 4'b0 || hit_cnt !== 0 || miss_cnt !== 0
        || resp_data !== 0 || mem_req_addr !== 0) begin
      errors++; $display("FAIL midreset_outputs: rdy=%b rv=%b rh=%b mv=%b hc=%0d mc=%0d rd=%h ma=%h, required all 0",
                         req_ready, resp_valid, resp_hit, mem_req_valid, hit_cnt, miss_cnt, resp_data, mem_req_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    issue(32'h0000_E004, a);
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_E000) begin
      errors++; $display("FAIL midreset_remiss: mem_req_valid=%b addr=%h, required 1 0000e000", mem_req_valid, mem_req_addr);
    end
    mem_accept(32'h0000_E000, 0, 1'b0);
    mem_beats(32'hE000_0000, 0, 16, 0);
    wait_resp(d, h, lat);
    checks++;
    if (d !== 32'hE000_0004 || h !== 1'b0 || miss_cnt !== 1) begin
      errors++; $display("FAIL midreset_refill: data=%h hit=%b miss_cnt=%0d, required e0000004 0 1", d, h, miss_cnt);
    end
  endtask

  task automatic test_params_sat();
    int n;
    n = 0;
    while (!p_req_ready && n < 60) begin @(negedge clk); n++; end
    p_req_valid = 1'b1; p_req_addr = 16'h00F7;
    @(negedge clk); p_req_valid = 1'b0;
    n = 0;
    while (!p_mem_req_valid && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (p_mem_req_valid !== 1'b1 || p_mem_req_addr !== 16'h00F4) begin
      errors++; $display("FAIL param_mem_req: valid=%b addr=%h, required 1 00f4", p_mem_req_valid, p_mem_req_addr);
    end
    p_mem_req_ready = 1'b1;
    @(negedge clk); p_mem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      p_mem_rsp_valid = 1'b1; p_mem_rsp_data = 32'h5500_0000 + k;
      @(negedge clk); p_mem_rsp_valid = 1'b0;
    end
    checks++;
    if (p_resp_valid !== 1'b1 || p_resp_data !== 32'h5500_0003 || p_resp_hit !== 1'b0 || p_miss_cnt !== 1) begin
      errors++; $display("FAIL param_refill: rv=%b data=%h hit=%b miss=%0d, required 1 55000003 0 1",
                         p_resp_valid, p_resp_data, p_resp_hit, p_miss_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      n = 0;
      while (!p_req_ready && n < 20) begin @(negedge clk); n++; end
      p_req_valid = 1'b1; p_req_addr = 16'h00F4 + 16'(i % 4);
      @(negedge clk); p_req_valid = 1'b0;
      n = 0;
      while (!p_resp_valid && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (p_resp_valid !== 1'b1 || p_resp_hit !== 1'b1 || p_resp_data !== 32'h5500_0000 + 32'(i % 4)) begin
        errors++; $display("FAIL param_hit %0d: rv=%b hit=%b data=%h, required 1 1 %h",
                           i, p_resp_valid, p_resp_hit, p_resp_data, 32'h5500_0000 + 32'(i % 4));
      end
    end
    checks++;
    if (p_hit_cnt !== 4'd15 || p_miss_cnt !== 4'd1) begin
      errors++; $display("FAIL param_saturate: hit_cnt=%0d miss_cnt=%0d, required 15 1", p_hit_cnt, p_miss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss_hit();
    test_conflict();
    test_flush_idle();
    test_backpressure();
    test_flush_refill();
    test_back_to_back();
    test_reset_mid_refill();
    test_params_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
